pc_select_mux: RTL and testbench

- Program-counter source selector for the datapath fetch stage.
- Chooses between the sequential PC-adder address and the branch target address.
- Presents the selected address combinationally, and also registers it as the next PC.
- Provides a one-cycle redirect pulse and an optional taken-branch statistics counter.

---
 rtl/pc_select_mux.sv | 82 ++++++++
 tb/tb_pc_select_mux.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pc_select_mux.sv
// Fetch-stage PC source selector: combinational branch/sequential mux plus registered next PC,
// one-cycle redirect pulse and an optional saturating taken-branch counter (MUXPC_BRANCH_CNT_EN).
module pc_select_mux #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_src,
    input  logic [ADDR_W-1:0] pc_adder_addr,
    input  logic [ADDR_W-1:0] branch_addr,
    input  logic              stall,
    output logic [ADDR_W-1:0] mux_pc_out,
    output logic [ADDR_W-1:0] pc_q,
    output logic              redirect,
    output logic [CNT_W-1:0]  branch_taken_cnt
);

    logic [ADDR_W-1:0] w_mux_pc;
    logic [ADDR_W-1:0] r_pc_q;
    logic              r_redirect;
    logic              w_accept;

    assign w_accept = ~stall;

    // Address select; an unknown select propagates X instead of silently picking a side.
    always_comb begin
        w_mux_pc = {ADDR_W{1'b0}};
        case (pc_src)
            1'b1:    w_mux_pc = branch_addr;
            1'b0:    w_mux_pc = pc_adder_addr;
            default: w_mux_pc = {ADDR_W{1'bx}};
        endcase
    end

    // Program counter: reset wins over stall, stall holds the current PC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc_q <= RESET_PC;
        end else if (w_accept) begin
            r_pc_q <= w_mux_pc;
        end else begin
            r_pc_q <= r_pc_q;
        end
    end

    // Redirect pulse: cleared on stall so a held branch is never reported twice.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_redirect <= 1'b0;
        end else if (w_accept) begin
            r_redirect <= pc_src;
        end else begin
            r_redirect <= 1'b0;
        end
    end

`ifdef MUXPC_BRANCH_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Taken-branch statistics, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_accept && pc_src && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign branch_taken_cnt = r_cnt;
`else
    assign branch_taken_cnt = {CNT_W{1'b0}};
`endif

    assign mux_pc_out = w_mux_pc;
    assign pc_q       = r_pc_q;
    assign redirect   = r_redirect;

endmodule

// File: tb/tb_pc_select_mux.sv
// Directed self-checking bench for pc_select_mux; expectations adapt to MUXPC_BRANCH_CNT_EN.
module tb_pc_select_mux;

`ifdef MUXPC_BRANCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        pc_src;
    logic [7:0]  pc_adder_addr;
    logic [7:0]  branch_addr;
    logic        stall;
    logic [7:0]  mux_pc_out;
    logic [7:0]  pc_q;
    logic        redirect;
    logic [15:0] branch_taken_cnt;

    int vectors;
    int miscompares;

    pc_select_mux #(.ADDR_W(8), .RESET_PC(8'h00), .CNT_W(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pc_src           (pc_src),
        .pc_adder_addr    (pc_adder_addr),
        .branch_addr      (branch_addr),
        .stall            (stall),
        .mux_pc_out       (mux_pc_out),
        .pc_q             (pc_q),
        .redirect         (redirect),
        .branch_taken_cnt (branch_taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] cnt_exp(input logic [15:0] v);
        return CNT_EN ? v : 16'h0000;
    endfunction

    task automatic test_comb_select();
        rst_n = 1'b0; stall = 1'b0;
        pc_src = 1'b1; pc_adder_addr = 8'h0F; branch_addr = 8'hF0;
        #1;
        vectors++;
        if (mux_pc_out !== 8'hF0) begin
            miscompares++;
            $display("FAIL comb_src1: got %h want %h", mux_pc_out, 8'hF0);
        end
        pc_src = 1'b0;
        #1;
        vectors++;
        if (mux_pc_out !== 8'h0F) begin
            miscompares++;
            $display("FAIL comb_src0: got %h want %h", mux_pc_out, 8'h0F);
        end
    endtask

    task automatic test_patterns();
        logic [7:0] adder_v [4];
        logic [7:0] br_v    [4];
        logic       src_v   [4];
        logic [7:0] exp_v   [4];
        adder_v = '{8'h55, 8'h55, 8'h00, 8'h00};
        br_v    = '{8'h44, 8'h44, 8'hFF, 8'hFF};
        src_v   = '{1'b1,  1'b0,  1'b1,  1'b0};
        exp_v   = '{8'h44, 8'h55, 8'hFF, 8'h00};
        for (int i = 0; i < 4; i++) begin
            pc_adder_addr = adder_v[i]; branch_addr = br_v[i]; pc_src = src_v[i];
            stall = i[0];
            #1;
            vectors++;
            if (mux_pc_out !== exp_v[i]) begin
                miscompares++;
                $display("FAIL pattern_%0d: got %h want %h", i, mux_pc_out, exp_v[i]);
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; pc_src = 1'b1; branch_addr = 8'h3C;
        step(); step();
        vectors++;
        if (pc_q !== 8'h00 || redirect !== 1'b0 || branch_taken_cnt !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_state: got pc=%h rd=%b cnt=%h want 00 0 0000", pc_q, redirect, branch_taken_cnt);
        end
        rst_n = 1'b1; pc_src = 1'b0; pc_adder_addr = 8'h01;
        step();
        vectors++;
        if (pc_q !== 8'h01 || redirect !== 1'b0 || branch_taken_cnt !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_release: got pc=%h rd=%b cnt=%h want 01 0 0000", pc_q, redirect, branch_taken_cnt);
        end
    endtask

    task automatic test_redirect_stall();
        pc_src = 1'b1; branch_addr = 8'h80; pc_adder_addr = 8'h02; stall = 1'b0;
        step();
        vectors++;
        if (pc_q !== 8'h80 || redirect !== 1'b1 || branch_taken_cnt !== cnt_exp(16'd1)) begin
            miscompares++;
            $display("FAIL branch_taken: got pc=%h rd=%b cnt=%h want 80 1 %h", pc_q, redirect, branch_taken_cnt, cnt_exp(16'd1));
        end
        stall = 1'b1; branch_addr = 8'h90;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (pc_q !== 8'h80 || redirect !== 1'b0 || branch_taken_cnt !== cnt_exp(16'd1)) begin
                miscompares++;
                $display("FAIL stall_hold_%0d: got pc=%h rd=%b cnt=%h want 80 0 %h", i, pc_q, redirect, branch_taken_cnt, cnt_exp(16'd1));
            end
        end
        stall = 1'b0; pc_src = 1'b0; pc_adder_addr = 8'h81;
        step();
        vectors++;
        if (pc_q !== 8'h81 || redirect !== 1'b0 || branch_taken_cnt !== cnt_exp(16'd1)) begin
            miscompares++;
            $display("FAIL seq_after_stall: got pc=%h rd=%b cnt=%h want 81 0 %h", pc_q, redirect, branch_taken_cnt, cnt_exp(16'd1));
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] tgt [2];
        tgt = '{8'h10, 8'h20};
        pc_src = 1'b1; stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            branch_addr = tgt[i];
            step();
            vectors++;
            if (pc_q !== tgt[i] || redirect !== 1'b1 || branch_taken_cnt !== cnt_exp(16'(i + 2))) begin
                miscompares++;
                $display("FAIL b2b_%0d: got pc=%h rd=%b cnt=%h want %h 1 %h", i, pc_q, redirect, branch_taken_cnt, tgt[i], cnt_exp(16'(i + 2)));
            end
        end
    endtask

    task automatic test_reset_vs_stall();
        rst_n = 1'b0; stall = 1'b1; pc_src = 1'b1; branch_addr = 8'h77;
        step();
        vectors++;
        if (pc_q !== 8'h00 || redirect !== 1'b0 || branch_taken_cnt !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_over_stall: got pc=%h rd=%b cnt=%h want 00 0 0000", pc_q, redirect, branch_taken_cnt);
        end
        rst_n = 1'b1; stall = 1'b0;
    endtask

    task automatic test_saturation();
        int first_n;
        first_n = CNT_EN ? 65535 : 20;
        pc_src = 1'b1; branch_addr = 8'hAA; stall = 1'b0;
        for (int i = 0; i < 100; i++) step();
        vectors++;
        if (branch_taken_cnt !== cnt_exp(16'd100) || pc_q !== 8'hAA || redirect !== 1'b1) begin
            miscompares++;
            $display("FAIL cnt_100: got cnt=%h pc=%h rd=%b want %h AA 1", branch_taken_cnt, pc_q, redirect, cnt_exp(16'd100));
        end
        for (int i = 100; i < first_n; i++) step();
        vectors++;
        if (branch_taken_cnt !== cnt_exp(16'hFFFF)) begin
            miscompares++;
            $display("FAIL cnt_reach_max: got %h want %h", branch_taken_cnt, cnt_exp(16'hFFFF));
        end
        for (int i = 0; i < 3; i++) step();
        vectors++;
        if (branch_taken_cnt !== cnt_exp(16'hFFFF) || redirect !== 1'b1) begin
            miscompares++;
            $display("FAIL cnt_no_wrap: got cnt=%h rd=%b want %h 1", branch_taken_cnt, redirect, cnt_exp(16'hFFFF));
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; stall = 1'b0; pc_src = 1'b0;
        pc_adder_addr = 8'h00; branch_addr = 8'h00;
        test_comb_select();
        test_patterns();
        test_reset();
        test_redirect_stall();
        test_back_to_back();
        test_reset_vs_stall();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
